// File: rtl/mips_multicycle_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if : IR fields, memory handshake and datapath controls
// Revision: 1.0
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
);
    logic [OPW-1:0]    opcode;
    logic [OPW-1:0]    funct;
    logic              zero;
    logic              mem_ready;
    logic              mem_rd;
    logic              mem_wr;
    logic              iord;
    logic              ir_we;
    logic              pc_we;
    logic [1:0]        pc_src;
    logic              ImmorReg;
    logic [ALUOPW-1:0] alu_op;
    logic              reg_we;
    logic              reg_dst;
    logic              wb_sel;
    logic              instr_done;
    logic              illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_rd, mem_wr, iord, ir_we, pc_we, pc_src, ImmorReg,
               alu_op, reg_we, reg_dst, wb_sel, instr_done, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_rd, mem_wr, iord, ir_we, pc_we, pc_src, ImmorReg,
               alu_op, reg_we, reg_dst, wb_sel, instr_done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl : multi-cycle MIPS control FSM (MIPS_CTRL_PERF_EN adds perf counters)
// Revision: 1.0
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus
`ifdef MIPS_CTRL_PERF_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           instr_cnt
`endif
);

    localparam logic [OPW-1:0] c_OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] c_OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] c_OP_ANDI  = OPW'(6'b001100);
    localparam logic [OPW-1:0] c_OP_ORI   = OPW'(6'b001101);
    localparam logic [OPW-1:0] c_OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] c_OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] c_OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] c_OP_J     = OPW'(6'b000010);

    localparam logic [OPW-1:0] c_FN_ADD   = OPW'(6'b100000);
    localparam logic [OPW-1:0] c_FN_SUB   = OPW'(6'b100010);
    localparam logic [OPW-1:0] c_FN_AND   = OPW'(6'b100100);
    localparam logic [OPW-1:0] c_FN_OR    = OPW'(6'b100101);
    localparam logic [OPW-1:0] c_FN_SLT   = OPW'(6'b101010);

    localparam logic [ALUOPW-1:0] c_ALU_ADD = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] c_ALU_SUB = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] c_ALU_AND = ALUOPW'(2);
    localparam logic [ALUOPW-1:0] c_ALU_OR  = ALUOPW'(3);
    localparam logic [ALUOPW-1:0] c_ALU_SLT = ALUOPW'(4);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    state_e             state_q, state_d;
    logic [OPW-1:0]     op_q, op_d;
    logic [OPW-1:0]     funct_q, funct_d;
    logic               imm_q, imm_d;
    logic               br_q, br_d;

    logic               w_mem_rd, w_mem_wr, w_iord, w_ir_we, w_pc_we;
    logic [1:0]         w_pc_src;
    logic [ALUOPW-1:0]  w_alu_op;
    logic               w_reg_we, w_reg_dst, w_wb_sel, w_instr_done, w_illegal;

    function automatic logic f_rtype_ok(input logic [OPW-1:0] fn);
        return (fn == c_FN_ADD) || (fn == c_FN_SUB) || (fn == c_FN_AND) ||
               (fn == c_FN_OR)  || (fn == c_FN_SLT);
    endfunction

    function automatic logic [ALUOPW-1:0] f_rtype_alu(input logic [OPW-1:0] fn);
        case (fn)
            c_FN_SUB: return c_ALU_SUB;
            c_FN_AND: return c_ALU_AND;
            c_FN_OR:  return c_ALU_OR;
            c_FN_SLT: return c_ALU_SLT;
            default:  return c_ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            funct_q <= '0;
            imm_q   <= 1'b1;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            imm_q   <= imm_d;
            br_q    <= br_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        funct_d      = funct_q;
        imm_d        = imm_q;
        br_d         = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_iord       = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = 2'd0;
        w_alu_op     = c_ALU_ADD;
        w_reg_we     = 1'b0;
        w_reg_dst    = 1'b0;
        w_wb_sel     = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                w_mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (bus.opcode)
                    c_OP_RTYPE: if (f_rtype_ok(bus.funct)) state_d = S_EXEC_R;
                    c_OP_ADDI, c_OP_ANDI, c_OP_ORI: state_d = S_EXEC_I;
                    c_OP_LW, c_OP_SW: state_d = S_ADDR;
                    c_OP_BEQ: state_d = S_BRANCH;
                    c_OP_J:   state_d = S_JUMP;
                    default: ;
                endcase
                if (state_d == S_FETCH) begin
                    w_illegal = 1'b1;
                end else begin
                    op_d    = bus.opcode;
                    funct_d = bus.funct;
                end
            end
            S_EXEC_R: begin
                w_alu_op  = f_rtype_alu(funct_q);
                w_reg_dst = 1'b1;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                if (op_q == c_OP_ANDI)     w_alu_op = c_ALU_AND;
                else if (op_q == c_OP_ORI) w_alu_op = c_ALU_OR;
                state_d = S_WB_ALU;
            end
            S_ADDR: state_d = (op_q == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                w_mem_rd = 1'b1;
                w_iord   = 1'b1;
                if (bus.mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                w_mem_wr = 1'b1;
                w_iord   = 1'b1;
                if (bus.mem_ready) begin
                    w_instr_done = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_WB_ALU: begin
                w_reg_we     = 1'b1;
                w_reg_dst    = (op_q == c_OP_RTYPE);
                w_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_WB_MEM: begin
                w_reg_we     = 1'b1;
                w_wb_sel     = 1'b1;
                w_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            // beq takes two BRANCH cycles: compare first, then commit on the settled zero flag
            S_BRANCH: begin
                w_alu_op = c_ALU_SUB;
                if (!br_q) begin
                    br_d = 1'b1;
                end else begin
                    w_pc_we      = bus.zero;
                    w_pc_src     = 2'd1;
                    w_instr_done = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_JUMP: begin
                w_pc_we      = 1'b1;
                w_pc_src     = 2'd2;
                w_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // B-operand select is registered on entry to an ALU state so the mux never sees a glitch
        if (state_d == S_EXEC_R || state_d == S_BRANCH) begin
            imm_d = 1'b1;
        end else if (state_d == S_EXEC_I || state_d == S_ADDR) begin
            imm_d = 1'b0;
        end
    end

    assign bus.mem_rd     = w_mem_rd;
    assign bus.mem_wr     = w_mem_wr;
    assign bus.iord       = w_iord;
    assign bus.ir_we      = w_ir_we;
    assign bus.pc_we      = w_pc_we;
    assign bus.pc_src     = w_pc_src;
    assign bus.ImmorReg   = imm_q;
    assign bus.alu_op     = w_alu_op;
    assign bus.reg_we     = w_reg_we;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.wb_sel     = w_wb_sel;
    assign bus.instr_done = w_instr_done;
    assign bus.illegal    = w_illegal;

`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            if (state_q != S_IDLE) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (w_instr_done)      instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl : random instruction stream, per-instruction scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        int         fw;
        int         mw;
        bit         abort;
    } instr_t;

    typedef struct {
        bit abort;
        bit ill;
        int cycles;
        int exec_cyc;
        bit chk_alu;
        int alu;
        int imm;
        int reg_we_n;
        int mem_wr_n;
        int mem_rd_n;
        int pc_we_n;
        int last_src;
        bit chk_wb;
        int wb_sel;
        bit chk_dst;
        int reg_dst;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    bit   run = 1'b0;
    bit   stim_done = 1'b0;
    int   nassert = 0;
    int   nfail = 0;

    instr_t stim_q[$];
    exp_t   exp_q[$];
    logic [5:0] op_tab [9];
    logic [5:0] fn_tab [5];

    mips_multicycle_ctrl_if #(.OPW(6), .ALUOPW(3)) bus ();

`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
    int retired = 0;
    mips_multicycle_ctrl #(.OPW(6), .ALUOPW(3)) dut (
        .clk(clk), .rst(rst), .bus(bus), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
    mips_multicycle_ctrl #(.OPW(6), .ALUOPW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint want);
        nassert++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic instr_t mk(logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw, bit ab);
        instr_t s;
        s.op = op; s.fn = fn; s.zero = z; s.fw = fw; s.mw = mw; s.abort = ab;
        return s;
    endfunction

    // Expected per-instruction behaviour straight from the ISA control rules
    function automatic exp_t model(instr_t s);
        exp_t e;
        int   a;
        e.abort = s.abort; e.ill = 0; e.exec_cyc = s.fw + 2; e.chk_alu = 0;
        e.alu = 0; e.imm = 0; e.reg_we_n = 0; e.mem_wr_n = 0; e.mem_rd_n = 0;
        e.pc_we_n = 1; e.last_src = 0; e.chk_wb = 0; e.wb_sel = 0;
        e.chk_dst = 0; e.reg_dst = 0; e.cycles = s.fw + 2;
        case (s.fn)
            6'b100000: a = 0;
            6'b100010: a = 1;
            6'b100100: a = 2;
            6'b100101: a = 3;
            6'b101010: a = 4;
            default:   a = -1;
        endcase
        case (s.op)
            6'b000000: begin
                if (a < 0) e.ill = 1;
                else begin
                    e.cycles = s.fw + 4; e.chk_alu = 1; e.alu = a; e.imm = 1;
                    e.reg_we_n = 1; e.chk_wb = 1; e.chk_dst = 1; e.reg_dst = 1;
                end
            end
            6'b001000, 6'b001100, 6'b001101: begin
                e.cycles = s.fw + 4; e.chk_alu = 1; e.imm = 0;
                e.alu = (s.op == 6'b001100) ? 2 : (s.op == 6'b001101) ? 3 : 0;
                e.reg_we_n = 1; e.chk_wb = 1; e.chk_dst = 1;
            end
            6'b100011: begin
                e.cycles = s.fw + s.mw + 5; e.chk_alu = 1; e.reg_we_n = 1;
                e.chk_wb = 1; e.wb_sel = 1; e.mem_rd_n = s.mw + 1;
            end
            6'b101011: begin
                e.cycles = s.fw + s.mw + 4; e.chk_alu = 1; e.mem_wr_n = s.mw + 1;
            end
            6'b000100: begin
                e.cycles = s.fw + 4; e.chk_alu = 1; e.alu = 1; e.imm = 1;
                if (s.zero) begin e.pc_we_n = 2; e.last_src = 1; end
            end
            6'b000010: begin
                e.cycles = s.fw + 3; e.pc_we_n = 2; e.last_src = 2;
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    // Memory responder and instruction issuer
    initial begin
        instr_t cur;
        int     wait_left = 0;
        int     mem_cyc = 0;
        bit     in_acc = 0;
        cur = mk(6'd0, 6'd0, 1'b0, 0, 0, 1'b0);
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!run || rst) begin
                in_acc = 0;
                bus.mem_ready = 1'b0;
                continue;
            end
            if ((bus.mem_rd || bus.mem_wr) && !in_acc) begin
                in_acc = 1;
                mem_cyc = 0;
                if (bus.mem_rd && !bus.iord) begin
                    if (stim_q.size() == 0) begin
                        stim_done = 1'b1;
                        wait_left = 1 << 30;
                    end else begin
                        cur = stim_q.pop_front();
                        bus.opcode = cur.op;
                        bus.funct  = cur.fn;
                        bus.zero   = cur.zero;
                        exp_q.push_back(model(cur));
                        wait_left = cur.fw;
                    end
                end else begin
                    wait_left = cur.mw;
                end
            end
            if (in_acc) begin
                if (cur.abort && bus.mem_wr && mem_cyc == 2) begin
                    rst = 1'b1;
                    #1;
                    check("abort_mem_wr_drop", bus.mem_wr, 0);
                    check("abort_reg_we", bus.reg_we, 0);
                    check("abort_idle_outs", {bus.mem_rd, bus.iord, bus.pc_we, bus.instr_done}, 0);
                    in_acc = 0;
                    bus.mem_ready = 1'b0;
                    repeat (2) @(posedge clk);
                    check("abort_immorreg", bus.ImmorReg, 1);
`ifdef MIPS_CTRL_PERF_EN
                    check("perf_cycle_zero", cycle_cnt, 0);
                    check("perf_instr_zero", instr_cnt, 0);
`endif
                    #1 rst = 1'b0;
                    continue;
                end
                mem_cyc++;
                if (wait_left > 0) begin
                    bus.mem_ready = 1'b0;
                    wait_left--;
                end else begin
                    bus.mem_ready = 1'b1;
                    in_acc = 0;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: gathers observations per instruction and scores them on retire/illegal
    initial begin
        exp_t e;
        bit   active = 0;
        int   cyc = 0, n_rwe = 0, n_mwr = 0, n_mrd = 0, n_pcwe = 0, n_irwe = 0;
        int   g_alu = 0, g_imm = 0, g_src = 0, g_wb = 0, g_dst = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
`ifdef MIPS_CTRL_PERF_EN
                retired = 0;
`endif
                if (active) begin
                    active = 0;
                    if (exp_q.size() == 0) check("abort_has_expect", 0, 1);
                    else begin
                        e = exp_q.pop_front();
                        check("abort_expected", 1, e.abort);
                    end
                end
                continue;
            end
            if (!run) continue;
            if (!active) begin
                if (bus.mem_rd && !bus.iord) begin
                    active = 1; cyc = 0; n_rwe = 0; n_mwr = 0; n_mrd = 0;
                    n_pcwe = 0; n_irwe = 0; g_alu = -1; g_imm = -1; g_src = 0;
                    g_wb = -1; g_dst = -1;
                end else begin
                    check("stray_outputs",
                          {bus.reg_we, bus.mem_wr, bus.pc_we, bus.instr_done, bus.illegal}, 0);
                    continue;
                end
            end else begin
                cyc++;
            end
            n_rwe  += int'(bus.reg_we);
            n_mwr  += int'(bus.mem_wr);
            n_mrd  += int'(bus.mem_rd && bus.iord);
            n_irwe += int'(bus.ir_we);
            if (bus.reg_we) begin g_wb = bus.wb_sel; g_dst = bus.reg_dst; end
            if (bus.pc_we) begin n_pcwe++; g_src = bus.pc_src; end
            if (exp_q.size() > 0 && cyc == exp_q[0].exec_cyc) begin
                g_alu = bus.alu_op;
                g_imm = bus.ImmorReg;
            end
            if (bus.instr_done || bus.illegal) begin
                active = 0;
`ifdef MIPS_CTRL_PERF_EN
                if (bus.instr_done) retired++;
`endif
                if (exp_q.size() == 0) begin
                    check("event_has_expect", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("not_aborted", 0, e.abort);
                    check("event_kind", {bus.instr_done, bus.illegal}, e.ill ? 1 : 2);
                    check("cycles", cyc + 1, e.cycles);
                    check("ir_we_count", n_irwe, 1);
                    check("reg_we_count", n_rwe, e.reg_we_n);
                    check("mem_wr_count", n_mwr, e.mem_wr_n);
                    check("mem_rd_data_count", n_mrd, e.mem_rd_n);
                    check("pc_we_count", n_pcwe, e.pc_we_n);
                    check("pc_src", g_src, e.last_src);
                    if (e.chk_alu) begin
                        check("alu_op", g_alu, e.alu);
                        check("ImmorReg", g_imm, e.imm);
                    end
                    if (e.chk_wb)  check("wb_sel", g_wb, e.wb_sel);
                    if (e.chk_dst) check("reg_dst", g_dst, e.reg_dst);
                end
            end
        end
    end

    initial begin
        int guard = 0;
        rst = 1'b1;
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
        op_tab = '{6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
                   6'b100011, 6'b101011, 6'b000100, 6'b000010};
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        stim_q.push_back(mk(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0));  // add
        stim_q.push_back(mk(6'b001101, 6'b000000, 1'b0, 0, 0, 1'b0));  // ori
        stim_q.push_back(mk(6'b100011, 6'b000000, 1'b0, 0, 2, 1'b0));  // lw, 2 waits
        stim_q.push_back(mk(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0));  // beq taken
        stim_q.push_back(mk(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0));  // beq not taken
        stim_q.push_back(mk(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0));  // illegal opcode
        stim_q.push_back(mk(6'b000000, 6'b000111, 1'b0, 0, 0, 1'b0));  // illegal funct
        stim_q.push_back(mk(6'b101011, 6'b000000, 1'b0, 0, 5, 1'b1));  // sw aborted by reset
        stim_q.push_back(mk(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0));  // add
        stim_q.push_back(mk(6'b101011, 6'b000000, 1'b0, 0, 1, 1'b0));  // sw
        stim_q.push_back(mk(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0));  // j
        for (int i = 0; i < 40; i++) begin
            int k;
            logic [5:0] op, fn;
            k  = $urandom_range(0, 9);
            op = (k == 9) ? 6'($urandom) : op_tab[k];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
            stim_q.push_back(mk(op, fn, 1'($urandom_range(0, 1)),
                                $urandom_range(0, 2), $urandom_range(0, 3), 1'b0));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero",
              {bus.mem_rd, bus.mem_wr, bus.iord, bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_op,
               bus.reg_we, bus.reg_dst, bus.wb_sel, bus.instr_done, bus.illegal}, 0);
        check("reset_immorreg", bus.ImmorReg, 1);
`ifdef MIPS_CTRL_PERF_EN
        check("perf_reset_cycle", cycle_cnt, 0);
        check("perf_reset_instr", instr_cnt, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("idle_no_mem_rd", bus.mem_rd, 0);
        @(negedge clk);
        check("fetch_mem_rd_iord", {bus.mem_rd, bus.iord}, 2);

        while (!(stim_done && exp_q.size() == 0) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check("run_timeout", 0, 1);
        repeat (2) @(negedge clk);
`ifdef MIPS_CTRL_PERF_EN
        check("perf_instr_cnt", instr_cnt, retired);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
`default_nettype wire
